// File: rtl/cpu_pkg.sv
// Shared definitions for the single-cycle core datapath.
//   WIDTH_DEF  : default datapath width (bits)
//   ADDR_W_DEF : default register-address width (bits)
//   REG_ZERO   : address of the hardwired-zero register
//   word_t     : one datapath word at the default width
package cpu_pkg;

  localparam int WIDTH_DEF  = 32;
  localparam int ADDR_W_DEF = 5;
  localparam int REG_ZERO   = 0;

  typedef logic [WIDTH_DEF-1:0] word_t;

endpackage

// File: rtl/reg_file_rport.sv
// Combinational read path for one port of reg_file.
// Ports:
//   rst, we, wa, wd : current-cycle write request (used only for bypass)
//   ra              : read address
//   regs            : storage array contents
//   rd              : read data (zero for REG_ZERO, bypassed wd, or regs[ra])
module reg_file_rport
  import cpu_pkg::*;
#(
  parameter int WIDTH  = WIDTH_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter bit FWD    = 1'b1
) (
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] wa,
  input  logic [WIDTH-1:0]  wd,
  input  logic [ADDR_W-1:0] ra,
  input  logic [WIDTH-1:0]  regs [2**ADDR_W],
  output logic [WIDTH-1:0]  rd
);

  localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(REG_ZERO);

  logic bypass;

  // A write landing at the coming edge is forwarded so the reader sees it
  // in the same cycle. Held off during reset because that write is dropped.
  assign bypass = FWD && !rst && we && (wa == ra);

  always_comb begin
    rd = '0;
    if (ra == ZERO_ADDR) begin
      rd = '0;
    end else if (bypass) begin
      rd = wd;
    end else begin
      rd = regs[ra];
    end
  end

endmodule

// File: rtl/reg_file.sv
// 2-read / 1-write register file with hardwired-zero register 0.
// Ports:
//   clk      : clock, rising edge
//   rst      : synchronous active-high reset, clears every register
//   we/wa/wd : write enable, address, data (write at rising edge)
//   ra1/rd1  : read port 1 address / combinational data
//   ra2/rd2  : read port 2 address / combinational data
// FWD=1 forwards a pending write to matching read ports in the same cycle.
module reg_file
  import cpu_pkg::*;
#(
  parameter int WIDTH  = WIDTH_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter bit FWD    = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] wa,
  input  logic [WIDTH-1:0]  wd,
  input  logic [ADDR_W-1:0] ra1,
  input  logic [ADDR_W-1:0] ra2,
  output logic [WIDTH-1:0]  rd1,
  output logic [WIDTH-1:0]  rd2
);

  localparam int DEPTH = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(REG_ZERO);

  logic [WIDTH-1:0] regs [DEPTH];

  // Reset wins over a write in the same cycle. Register 0 is never written,
  // so after the first reset it holds zero permanently.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
    end else if (we && (wa != ZERO_ADDR)) begin
      regs[wa] <= wd;
    end
  end

  reg_file_rport #(.WIDTH(WIDTH), .ADDR_W(ADDR_W), .FWD(FWD)) u_rport1 (
    .rst  (rst),
    .we   (we),
    .wa   (wa),
    .wd   (wd),
    .ra   (ra1),
    .regs (regs),
    .rd   (rd1)
  );

  reg_file_rport #(.WIDTH(WIDTH), .ADDR_W(ADDR_W), .FWD(FWD)) u_rport2 (
    .rst  (rst),
    .we   (we),
    .wa   (wa),
    .wd   (wd),
    .ra   (ra2),
    .regs (regs),
    .rd   (rd2)
  );

endmodule

// File: tb/tb_reg_file.sv
module tb_reg_file;

  localparam int W  = 32;
  localparam int AW = 5;
  localparam int N  = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          we;
  logic [AW-1:0] wa;
  logic [W-1:0]  wd;
  logic [AW-1:0] ra1;
  logic [AW-1:0] ra2;
  logic [W-1:0]  rd1_f, rd2_f;
  logic [W-1:0]  rd1_n, rd2_n;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] mdl [N];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  reg_file #(.WIDTH(W), .ADDR_W(AW), .FWD(1'b1)) dut (
    .clk(clk), .rst(rst), .we(we), .wa(wa), .wd(wd),
    .ra1(ra1), .ra2(ra2), .rd1(rd1_f), .rd2(rd2_f)
  );

  reg_file #(.WIDTH(W), .ADDR_W(AW), .FWD(1'b0)) dut_nf (
    .clk(clk), .rst(rst), .we(we), .wa(wa), .wd(wd),
    .ra1(ra1), .ra2(ra2), .rd1(rd1_n), .rd2(rd2_n)
  );

  // ---------------- checker ----------------
  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Expected read value taken from the reference array and the pending write.
  function automatic logic [W-1:0] exp_rd(input logic [AW-1:0] ra, input bit fwd);
    if (ra == '0) return '0;
    if (fwd && !rst && we && (wa == ra)) return wd;
    return mdl[ra];
  endfunction

  // ---------------- driver tasks ----------------
  task automatic set_in(input logic r, input logic w, input logic [AW-1:0] a,
                        input logic [W-1:0] d, input logic [AW-1:0] r1,
                        input logic [AW-1:0] r2);
    rst = r; we = w; wa = a; wd = d; ra1 = r1; ra2 = r2;
  endtask

  // One clock: drive, push expectations, compare at negedge, clock the
  // reference array at the posedge.
  task automatic cycle(input string tag, input logic r, input logic w,
                       input logic [AW-1:0] a, input logic [W-1:0] d,
                       input logic [AW-1:0] r1, input logic [AW-1:0] r2);
    set_in(r, w, a, d, r1, r2);
    exp_q.push_back(exp_rd(r1, 1'b1));
    exp_q.push_back(exp_rd(r2, 1'b1));
    exp_q.push_back(exp_rd(r1, 1'b0));
    exp_q.push_back(exp_rd(r2, 1'b0));
    @(negedge clk);
    check({tag, ".rd1_fwd"},   rd1_f, exp_q.pop_front());
    check({tag, ".rd2_fwd"},   rd2_f, exp_q.pop_front());
    check({tag, ".rd1_nofwd"}, rd1_n, exp_q.pop_front());
    check({tag, ".rd2_nofwd"}, rd2_n, exp_q.pop_front());
    @(posedge clk);
    if (r) begin
      for (int i = 0; i < N; i++) mdl[i] = '0;
    end else if (w && a != '0) begin
      mdl[a] = d;
    end
    #1;
  endtask

  // Idle read with fixed expected constants on both DUTs.
  task automatic peek(input string tag, input logic [AW-1:0] r1, input logic [AW-1:0] r2,
                      input logic [W-1:0] e1, input logic [W-1:0] e2);
    set_in(1'b0, 1'b0, '0, '0, r1, r2);
    #1;
    check({tag, ".rd1_fwd"},   rd1_f, e1);
    check({tag, ".rd2_fwd"},   rd2_f, e2);
    check({tag, ".rd1_nofwd"}, rd1_n, e1);
    check({tag, ".rd2_nofwd"}, rd2_n, e2);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    set_in(1'b1, 1'b0, '0, '0, '0, '0);
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) mdl[i] = '0;

    // reset state
    peek("reset_r0_r31", 5'd0, 5'd31, 32'h0, 32'h0);

    // reset clears written data
    cycle("wr_r5", 1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 5'd5, 5'd1);
    peek("r5_written", 5'd5, 5'd5, 32'hDEADBEEF, 32'hDEADBEEF);
    cycle("rst_pulse", 1'b1, 1'b0, '0, '0, 5'd5, 5'd5);
    peek("reset_clear", 5'd5, 5'd5, 32'h0, 32'h0);

    // basic write/read
    cycle("wr_r3", 1'b0, 1'b1, 5'd3, 32'h12345678, 5'd1, 5'd2);
    peek("basic_read", 5'd3, 5'd0, 32'h12345678, 32'h0);

    // zero register: no bypass, no store
    set_in(1'b0, 1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0);
    #1;
    check("zero_nobypass", rd1_f, 32'h0);
    @(posedge clk); #1;
    peek("zero_after", 5'd0, 5'd0, 32'h0, 32'h0);

    // bypass vs no bypass
    cycle("wr_r7", 1'b0, 1'b1, 5'd7, 32'h00000011, 5'd7, 5'd7);
    set_in(1'b0, 1'b1, 5'd7, 32'h00000022, 5'd7, 5'd7);
    #1;
    check("byp.rd1_fwd",   rd1_f, 32'h00000022);
    check("byp.rd2_fwd",   rd2_f, 32'h00000022);
    check("byp.rd1_nofwd", rd1_n, 32'h00000011);
    check("byp.rd2_nofwd", rd2_n, 32'h00000011);
    @(posedge clk); #1;
    mdl[7] = 32'h00000022;
    peek("byp_after", 5'd7, 5'd7, 32'h00000022, 32'h00000022);

    // reset priority over write, bypass suppressed during reset
    cycle("wr_r9", 1'b0, 1'b1, 5'd9, 32'h000000AA, 5'd9, 5'd9);
    set_in(1'b1, 1'b1, 5'd9, 32'h00000055, 5'd9, 5'd9);
    #1;
    check("rstpri.during", rd1_f, 32'h000000AA);
    @(posedge clk); #1;
    for (int i = 0; i < N; i++) mdl[i] = '0;
    peek("rstpri.after", 5'd9, 5'd9, 32'h0, 32'h0);

    // sweep every address, then write-after-write to the same address
    for (int i = 0; i < N; i++) begin
      cycle("sweep_wr", 1'b0, 1'b1, AW'(i), $urandom(), AW'(i), AW'((i + 1) % N));
    end
    for (int i = 0; i < N; i++) begin
      cycle("sweep_rd", 1'b0, 1'b0, '0, '0, AW'(i), AW'(N - 1 - i));
    end
    cycle("waw1", 1'b0, 1'b1, 5'd12, 32'hAAAA0001, 5'd12, 5'd12);
    cycle("waw2", 1'b0, 1'b1, 5'd12, 32'hBBBB0002, 5'd12, 5'd12);
    peek("waw_last", 5'd12, 5'd12, 32'hBBBB0002, 32'hBBBB0002);

    // random traffic
    for (int k = 0; k < 300; k++) begin
      cycle("rand", ($urandom_range(0, 49) == 0), ($urandom_range(0, 1) == 1),
            AW'($urandom_range(0, N - 1)), $urandom(),
            AW'($urandom_range(0, N - 1)), AW'($urandom_range(0, N - 1)));
    end

    // final report
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/reg_file.md
Name: reg_file

Overview:
- 2-read / 1-write general-purpose register file for the single-cycle processor datapath.
- Sits between the writeback-select MUX output (write data) and the ALU operand inputs (read data).
- It is the write-side counterpart of the operand-select MUX: it decodes an address to store one value, and the MUX selects one of several values to read.
- Register 0 is hardwired to zero, per the MIPS/RISC-V convention used by the core.

Parameters:
- WIDTH, 32, data width of each register and of the read/write data ports.
- ADDR_W, 5, address width; depth = 2**ADDR_W registers (32 by default).
- FWD, 1, 1 = same-cycle write-to-read bypass enabled; 0 = read returns the stored value only.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- we  input  1  write enable.
- wa  input  ADDR_W  write address.
- wd  input  WIDTH  write data.
- ra1  input  ADDR_W  read address, port 1.
- ra2  input  ADDR_W  read address, port 2.
- rd1  output  WIDTH  read data, port 1 (combinational).
- rd2  output  WIDTH  read data, port 2 (combinational).

Behaviour:
- Clock/reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset: on a posedge clk with rst=1, all 2**ADDR_W registers clear to 0. rst has priority over we, so no write occurs that cycle. After that edge, rd1 and rd2 read 0 for every address.
- Reset mid-operation: a write presented in the same cycle as rst=1 is dropped. A register written before reset reads 0 after the reset edge.
- Write: on a posedge clk with rst=0, we=1 and wa!=0, reg[wa] <= wd. The write is visible on the read ports from the cycle after the edge (1-cycle write latency).
- Write to address 0: ignored in all cases; reg[0] stays 0.
- we=0: no register changes. wa and wd are don't-care.
- Read: rd1 = reg[ra1] and rd2 = reg[ra2], combinational with zero latency. ra=0 always gives 0.
- Bypass, FWD=1: if rst=0, we=1, wa==raN and wa!=0, then rdN = wd in the same cycle, before the edge. Otherwise rdN = reg[raN]. Both ports bypass independently; ra1==ra2==wa bypasses both.
- Bypass, FWD=0: rdN shows the old reg[raN] until the write edge and the new value after it.
- Bypass is suppressed while rst=1, so reads return stored contents.
- Simultaneous reads of the same address return identical data on both ports.
- No X-propagation on unwritten addresses: the array is fully defined after the first reset. Before the first reset, contents are undefined and the bench must reset first.
- Width rules:
  - No sign or zero extension inside the block; wd is stored bit-exact.
  - Addresses are used modulo 2**ADDR_W with no range check.

Decomposition:
- Shared package `cpu_pkg` holds:
  - WIDTH_DEF=32 and ADDR_W_DEF=5.
  - REG_ZERO = 0 (address of the hardwired-zero register).
  - the `word_t` typedef (logic [WIDTH-1:0]).
- One sub-module, `reg_file_rport`: the combinational read path (zero-address check, bypass compare, array select). It is instantiated twice, for ports 1 and 2.
- The storage array and the write/reset logic live in `reg_file`.

Test Plan:
- Reset clear: write 0xDEADBEEF to r5, then assert rst for 1 cycle. After the edge, ra1=5 and ra2=5 -> rd1=rd2=0x00000000.
- Basic write/read: we=1, wa=3, wd=0x12345678, then one edge, then we=0, ra1=3, ra2=0 -> rd1=0x12345678, rd2=0x00000000.
- Zero register: we=1, wa=0, wd=0xFFFFFFFF, then one edge, ra1=0 -> rd1=0x00000000. With FWD=1 and the same write pending, ra1=0 -> rd1=0x00000000 (no bypass).
- Bypass: FWD=1, r7 holds 0x00000011. Present we=1, wa=7, wd=0x00000022, ra1=7, ra2=7 before the edge -> rd1=rd2=0x00000022. With FWD=0, same stimulus -> rd1=rd2=0x00000011 before the edge and 0x00000022 after it.
- Reset priority: r9 holds 0x000000AA. In the same cycle, rst=1, we=1, wa=9, wd=0x00000055. After the edge, ra1=9 -> rd1=0x00000000, and rd1 is not 0x00000055 in that cycle.
- File-driven sweep: read vectors (we, wa, wd, ra1, ra2, exp_rd1, exp_rd2) with $fscanf, one per clk. Compare on each posedge, stop with "testcase fail!" on the first mismatch, and print "Pass!" at EOF. Cover all 32 addresses and write-after-write to the same address (last value wins).
